uart_tx_fifo: RTL and testbench

- UART transmitter for the board's `tx` pin, fed by a small write FIFO.
- The SoC writes bytes without waiting. The block serialises them as 8N1 frames at `BAUD`, derived from the board clock `BOARD_CK`.
- It is the transmit-direction counterpart of the UART receive path on `rx`, and is instantiated inside `dut` next to that receiver.

---
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity bit
module uart_tx_fifo #(
    parameter int BOARD_CK   = 32000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);
    localparam int DIV = (BOARD_CK + BAUD / 2) / BAUD;
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic          ready, push, pop, bit_end;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;
    state_t        state;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    assign full    = level == (AW + 1)'(FIFO_DEPTH);
    assign push    = wr_en && !full;
    assign bit_end = cnt == LAST;
    assign pop     = ready && level != 0 && (state == IDLE || (state == STOP && bit_end));
    assign busy    = state != IDLE || level != 0;

    // byte storage; written only when a slot is free
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wr_data;
    end

    // pointers, occupancy, sticky overflow; ready delays head visibility by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overflow <= 1'b0;
            ready    <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level    <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            overflow <= overflow || (wr_en && full);
            ready    <= level != 0;
        end
    end

    // frame sequencer: start, 8 data bits LSB first, optional parity, stop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tx    <= 1'b1;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
            if (pop) begin
                sh    <= mem[rp];
`ifdef UART_TX_PARITY_EN
                par   <= ^mem[rp];
`endif
                state <= START;
                tx    <= 1'b0;
            end else begin
                case (state)
                    IDLE: tx <= 1'b1;
                    START: if (bit_end) begin
                        state <= DATA;
                        tx    <= sh[0];
                        idx   <= '0;
                    end
                    DATA: if (bit_end) begin
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                            tx  <= sh[1];
                            sh  <= {1'b0, sh[7:1]};
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
`endif
                    STOP: if (bit_end) state <= IDLE;
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks of uart_tx_fifo against a frame-timing model
module tb_uart_tx_fifo;
    localparam int CK = 160, BD = 10, DEPTH = 4, DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * DIV;
`else
    localparam int FRAME = 10 * DIV;
`endif

    logic       clk = 1'b0, reset = 1'b1, wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, overflow, busy, tx;
    logic [2:0] level;

    uart_tx_fifo #(.BOARD_CK(CK), .BAUD(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .level(level), .overflow(overflow), .busy(busy), .tx(tx)
    );

    always #5 clk = ~clk;

    int         total = 0, bad = 0, cyc = 0;
    int         acc_t[$], st_t[$];
    logic [7:0] acc_d[$];
    logic       m_ovf = 1'b0;

    // bytes accepted up to edge t minus frames started up to edge t
    function automatic int m_level(int t);
        int n = 0;
        foreach (acc_t[i]) begin
            if (acc_t[i] <= t) n++;
            if (st_t[i] <= t) n--;
        end
        return n;
    endfunction

    function automatic logic m_tx(int t);
        foreach (st_t[i]) begin
            if (t >= st_t[i] && t < st_t[i] + FRAME) begin
                int b = (t - st_t[i]) / DIV;
                if (b == 0) return 1'b0;
                if (b <= 8) return acc_d[i][b-1];
`ifdef UART_TX_PARITY_EN
                if (b == 9) return ^acc_d[i];
`endif
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic m_busy(int t);
        if (m_level(t) > 0) return 1'b1;
        foreach (st_t[i]) if (t >= st_t[i] && t < st_t[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        chk("tx", {31'b0, tx}, {31'b0, m_tx(cyc)});
        chk("level", {29'b0, level}, m_level(cyc));
        chk("full", {31'b0, full}, {31'b0, m_level(cyc) == DEPTH});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("busy", {31'b0, busy}, {31'b0, m_busy(cyc)});
    endtask

    // one clock edge; the model accepts a write if the FIFO was not full before the edge
    task automatic tick(input logic we, input logic [7:0] d);
        int s;
        wr_en = we;
        wr_data = d;
        @(posedge clk);
        cyc++;
        if (we && !reset) begin
            if (m_level(cyc - 1) < DEPTH) begin
                s = cyc + 2;
                if (st_t.size() > 0 && st_t[$] + FRAME > s) s = st_t[$] + FRAME;
                acc_t.push_back(cyc);
                acc_d.push_back(d);
                st_t.push_back(s);
            end else begin
                m_ovf = 1'b1;
            end
        end
        #1 check_all();
    endtask

    task automatic drain();
        int n = 0;
        while (m_busy(cyc) && n < 5000) begin
            tick(1'b0, 8'h00);
            n++;
        end
        chk("drain_bound", {31'b0, m_busy(cyc)}, 32'd0);
        repeat (5) tick(1'b0, 8'h00);
    endtask

    initial begin
        int n;
        repeat (2) tick(1'b0, 8'h00);
        reset = 1'b0;
        tick(1'b0, 8'h00);

        tick(1'b1, 8'hA5);
        tick(1'b0, 8'h00);
        chk("lat_n1", {31'b0, tx}, 32'd1);
        tick(1'b0, 8'h00);
        chk("lat_n2", {31'b0, tx}, 32'd0);
        drain();

        tick(1'b1, 8'h00);
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'h55);
        chk("b2b_peak", {29'b0, level}, 32'd2);
        drain();

        for (int i = 0; i < 6; i++) tick(1'b1, 8'($urandom));
        chk("full_flag", {31'b0, full}, 32'd1);
        chk("ovf_flag", {31'b0, overflow}, 32'd1);
        drain();
        chk("ovf_held", {31'b0, overflow}, 32'd1);

        tick(1'b1, 8'h3A);
        repeat (20) tick(1'b0, 8'h00);
        tick(1'b1, 8'hC6);
        n = 0;
        while (cyc < st_t[$] - 1 && n < 1000) begin
            tick(1'b0, 8'h00);
            n++;
        end
        tick(1'b1, 8'h81);
        chk("simul_level", {29'b0, level}, 32'd1);
        drain();

        for (int i = 0; i < 600; i++) tick($urandom_range(0, 99) < 3, 8'($urandom));
        drain();

        tick(1'b1, 8'h96);
        n = 0;
        while (cyc < st_t[$] + 4 * DIV + 5 && n < 1000) begin
            tick(1'b0, 8'h00);
            n++;
        end
        #3 reset = 1'b1;
        #1;
        acc_t.delete();
        acc_d.delete();
        st_t.delete();
        m_ovf = 1'b0;
        check_all();
        repeat (2) tick(1'b0, 8'h00);
        reset = 1'b0;
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h3C);
        drain();

        tick(1'b1, 8'h07);
        drain();
        tick(1'b1, 8'h03);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
